// File: rtl/toeplitz_sum.sv
// toeplitz_sum: GF(2) accumulation stage of the Toeplitz hash. Each qualified column is
// ANDed with the next raw-key bit and XORed into a ROW_W accumulator split into lanes.
module toeplitz_sum_lane #(
    parameter int LANE_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              take_i,
    input  logic              kb_i,
    input  logic              last_i,
    input  logic [LANE_W-1:0] row_i,
    output logic [LANE_W-1:0] hash_o
);
    logic [LANE_W-1:0] acc_q, acc_d, hash_q;

    always_comb begin
        acc_d = acc_q ^ (kb_i ? row_i : '0);
    end

    // On the last column the finished slice goes straight to hash and the
    // accumulator restarts clean for the next block.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            hash_q <= '0;
        end else if (take_i) begin
            if (last_i) begin
                hash_q <= acc_d;
                acc_q  <= '0;
            end else begin
                acc_q  <= acc_d;
            end
        end
    end

    assign hash_o = hash_q;
endmodule

module toeplitz_sum #(
    parameter int ROW_W  = 3072,
    parameter int N_COLS = 4096,
    parameter int KEY_W  = 32,
    parameter int LANE_W = 8     // must divide ROW_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [ROW_W-1:0] shift_row,
    input  logic             sum_en,
    input  logic [KEY_W-1:0] key_data,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [ROW_W-1:0] hash_out,
    output logic             hash_valid,
    input  logic             hash_ack,
    output logic             busy,
    output logic             err
);
    localparam int NUM_LANES = ROW_W / LANE_W;
    localparam int CNT_W     = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int PTR_W     = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(N_COLS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(KEY_W - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [PTR_W-1:0] bit_ptr_q, bit_ptr_d;
    logic [KEY_W-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             hash_valid_q, hash_valid_d;
    logic             err_q, err_d;

    logic take, kb, bit_last, col_last, load, key_ready_raw;

    logic [NUM_LANES-1:0][LANE_W-1:0] row_lanes, hash_lanes;

    assign take          = sum_en & buf_full_q & (state_q == ST_ACCUM);
    assign kb            = buf_q[bit_ptr_q];
    assign bit_last      = (bit_ptr_q == PTR_LAST);
    assign col_last      = (col_cnt_q == COL_LAST);
    // Accepting a word on the last-bit take keeps the buffer full with no bubble.
    assign key_ready_raw = ~buf_full_q | (take & bit_last);
    assign load          = key_valid & key_ready;

    assign row_lanes = shift_row;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        toeplitz_sum_lane #(.LANE_W(LANE_W)) u_lane (
            .clk_i  (clk_in),
            .rst_ni (rst),
            .take_i (take),
            .kb_i   (kb),
            .last_i (col_last),
            .row_i  (row_lanes[l]),
            .hash_o (hash_lanes[l])
        );
    end

    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        bit_ptr_d    = bit_ptr_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        hash_valid_d = hash_valid_q;
        err_d        = err_q;

        if (take) begin
            if (bit_last) begin
                bit_ptr_d  = '0;
                buf_full_d = 1'b0;
            end else begin
                bit_ptr_d  = bit_ptr_q + PTR_W'(1);
            end
            if (col_last) begin
                col_cnt_d    = '0;
                hash_valid_d = 1'b1;
                state_d      = ST_DONE;
            end else begin
                col_cnt_d    = col_cnt_q + CNT_W'(1);
            end
        end

        if (load) begin
            buf_d      = key_data;
            buf_full_d = 1'b1;
            bit_ptr_d  = '0;
        end

        // Any column not taken is lost for good; flag it until reset.
        if (sum_en && !take) begin
            err_d = 1'b1;
        end

        if ((state_q == ST_DONE) && hash_ack) begin
            hash_valid_d = 1'b0;
            state_d      = ST_ACCUM;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q      <= ST_ACCUM;
            col_cnt_q    <= '0;
            bit_ptr_q    <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            hash_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            bit_ptr_q    <= bit_ptr_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            hash_valid_q <= hash_valid_d;
            err_q        <= err_d;
        end
    end

    // Outputs read as zero for the whole cycle in which reset is asserted.
    assign key_ready  = rst & key_ready_raw;
    assign hash_out   = rst ? hash_lanes : '0;
    assign hash_valid = rst & hash_valid_q;
    assign busy       = rst & (state_q == ST_ACCUM) & (col_cnt_q != '0);
    assign err        = rst & err_q;
endmodule

// File: tb/tb_toeplitz_sum.sv
// Directed bench for toeplitz_sum: a small config (8/4/4) driven from a vector table
// and hand sequences, plus the default config streamed with a bit-level model.
module tb_toeplitz_sum;
    localparam int D_ROW = 3072, D_COLS = 4096, D_KEY = 32;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       s_rst, s_se, s_kv, s_kr, s_hv, s_ack, s_busy, s_err;
    logic [7:0] s_row, s_hash;
    logic [3:0] s_kd;

    logic             d_rst, d_se, d_kv, d_kr, d_hv, d_ack, d_busy, d_err;
    logic [D_ROW-1:0] d_row, d_hash;
    logic [D_KEY-1:0] d_kd;

    toeplitz_sum #(.ROW_W(8), .N_COLS(4), .KEY_W(4), .LANE_W(4)) u_small (
        .clk_in(clk_in), .rst(s_rst), .shift_row(s_row), .sum_en(s_se),
        .key_data(s_kd), .key_valid(s_kv), .key_ready(s_kr), .hash_out(s_hash),
        .hash_valid(s_hv), .hash_ack(s_ack), .busy(s_busy), .err(s_err)
    );

    toeplitz_sum u_dflt (
        .clk_in(clk_in), .rst(d_rst), .shift_row(d_row), .sum_en(d_se),
        .key_data(d_kd), .key_valid(d_kv), .key_ready(d_kr), .hash_out(d_hash),
        .hash_valid(d_hv), .hash_ack(d_ack), .busy(d_busy), .err(d_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [D_ROW-1:0] act, input logic [D_ROW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ..%0h expected ..%0h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic s_drive(input logic se, input logic [7:0] row, input logic kv,
                           input logic [3:0] kd, input logic ack);
        @(negedge clk_in);
        s_se = se; s_row = row; s_kv = kv; s_kd = kd; s_ack = ack;
        #1;
    endtask

    function automatic logic [31:0] kw(input int i);
        if (i < 128) return 32'hFFFF_FFFF;
        return 32'h9E37_79B9 ^ (32'(i) * 32'h0100_0193);
    endfunction

    function automatic logic [D_ROW-1:0] rowv(input int c);
        return {96{32'(c)}};
    endfunction

    typedef struct packed {
        logic       se;
        logic [7:0] row;
        logic       kv;
        logic [3:0] kd;
        logic       ack;
        logic       e_kr;
        logic       e_hv;
        logic [7:0] e_hash;
        logic       e_err;
        logic       e_busy;
    } vec_t;

    vec_t vt [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w, g;
        logic [31:0]      word;
        logic [D_ROW-1:0] exp_h;

        //          se  row    kv kd    ack  kr  hv  hash   err busy
        vt[0] = '{1'b0, 8'h00, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1] = '{1'b1, 8'h01, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'h02, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'h04, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[4] = '{1'b1, 8'h08, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[5] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'h0B, 1'b0, 1'b0};
        vt[6] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 8'h0B, 1'b0, 1'b0};
        vt[7] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h0B, 1'b0, 1'b0};

        s_rst = 0; s_se = 0; s_row = 0; s_kv = 0; s_kd = 0; s_ack = 0;
        d_rst = 0; d_se = 0; d_row = '0; d_kv = 0; d_kd = 0; d_ack = 0;

        // Reset cycle: outputs forced low
        @(negedge clk_in); #1;
        chk("s_rst key_ready", s_kr, 0);
        chk("s_rst hash_valid", s_hv, 0);
        chk("s_rst hash_out", s_hash, 0);
        chk("s_rst err", s_err, 0);
        chk("d_rst key_ready", d_kr, 0);
        chk("d_rst hash_valid", d_hv, 0);
        chk_wide("d_rst hash_out", d_hash, '0);
        @(negedge clk_in);
        s_rst = 1; d_rst = 1;

        // Small config, table-driven basic block (key 1011 -> 0B) and ack
        for (int i = 0; i < 8; i++) begin
            s_drive(vt[i].se, vt[i].row, vt[i].kv, vt[i].kd, vt[i].ack);
            chk($sformatf("vec%0d key_ready", i), s_kr, vt[i].e_kr);
            chk($sformatf("vec%0d hash_valid", i), s_hv, vt[i].e_hv);
            chk($sformatf("vec%0d hash_out", i), s_hash, vt[i].e_hash);
            chk($sformatf("vec%0d err", i), s_err, vt[i].e_err);
            chk($sformatf("vec%0d busy", i), s_busy, vt[i].e_busy);
        end

        // Hold in DONE with dropped columns and a key preload, then ack
        s_drive(0, 8'h00, 1, 4'hF, 0);
        s_drive(1, 8'h10, 0, 4'h0, 0);
        s_drive(1, 8'h20, 0, 4'h0, 0);
        s_drive(1, 8'h40, 0, 4'h0, 0);
        s_drive(1, 8'h80, 0, 4'h0, 0);
        for (int i = 0; i < 10; i++) begin
            s_drive(logic'(i % 2), 8'hFF, i == 0, 4'h1, 0);
            chk($sformatf("hold%0d hash_valid", i), s_hv, 1);
            chk($sformatf("hold%0d hash_out", i), s_hash, 8'hF0);
            chk($sformatf("hold%0d key_ready", i), s_kr, i == 0);
            chk($sformatf("hold%0d err", i), s_err, i >= 2);
        end
        s_drive(1, 8'hFF, 0, 4'h0, 1);
        chk("ack hash_valid", s_hv, 1);
        s_drive(1, 8'h11, 0, 4'h0, 0);
        chk("post-ack hash_valid", s_hv, 0);
        chk("post-ack err", s_err, 1);
        chk("post-ack hash_out", s_hash, 8'hF0);
        s_drive(1, 8'h22, 0, 4'h0, 0);
        s_drive(1, 8'h44, 0, 4'h0, 0);
        s_drive(1, 8'h88, 0, 4'h0, 0);
        s_drive(0, 8'h00, 0, 4'h0, 0);
        chk("fresh block hash_valid", s_hv, 1);
        chk("fresh block hash_out", s_hash, 8'h11);
        s_drive(0, 8'h00, 0, 4'h0, 1);
        s_drive(0, 8'h00, 0, 4'h0, 0);

        // Reset after 2 of 4 columns
        s_drive(0, 8'h00, 1, 4'hF, 0);
        s_drive(1, 8'h01, 0, 4'h0, 0);
        s_drive(1, 8'h02, 0, 4'h0, 0);
        s_drive(0, 8'h00, 0, 4'h0, 0);
        chk("pre-rst busy", s_busy, 1);
        chk("pre-rst err", s_err, 1);
        @(negedge clk_in);
        s_rst = 0; #1;
        chk("mid-rst hash_valid", s_hv, 0);
        chk("mid-rst hash_out", s_hash, 0);
        chk("mid-rst err", s_err, 0);
        chk("mid-rst key_ready", s_kr, 0);
        chk("mid-rst busy", s_busy, 0);
        @(negedge clk_in);
        s_rst = 1; #1;
        chk("post-rst key_ready", s_kr, 1);
        chk("post-rst err", s_err, 0);
        chk("post-rst hash_out", s_hash, 0);
        s_drive(0, 8'h00, 1, 4'h9, 0);
        s_drive(1, 8'h10, 0, 4'h0, 0);
        s_drive(1, 8'h20, 0, 4'h0, 0);
        s_drive(1, 8'h40, 0, 4'h0, 0);
        s_drive(1, 8'h80, 0, 4'h0, 0);
        s_drive(0, 8'h00, 0, 4'h0, 0);
        chk("post-rst block hash_valid", s_hv, 1);
        chk("post-rst block hash_out", s_hash, 8'h90);
        s_drive(0, 8'h00, 0, 4'h0, 1);

        // Column with empty key buffer is dropped
        s_drive(1, 8'hFF, 0, 4'h0, 0);
        chk("empty err before", s_err, 0);
        s_drive(0, 8'h00, 1, 4'h6, 0);
        chk("empty err set", s_err, 1);
        chk("empty busy", s_busy, 0);
        s_drive(1, 8'h01, 0, 4'h0, 0);
        s_drive(1, 8'h02, 0, 4'h0, 0);
        s_drive(1, 8'h04, 0, 4'h0, 0);
        s_drive(1, 8'h08, 0, 4'h0, 0);
        s_drive(0, 8'h00, 0, 4'h0, 0);
        chk("empty block hash_valid", s_hv, 1);
        chk("empty block hash_out", s_hash, 8'h06);
        s_drive(0, 8'h00, 0, 4'h0, 1);

        // Default config: zero-bubble streaming, all-ones key block then patterned key block
        @(negedge clk_in);
        d_kv = 1; d_kd = kw(0); #1;
        chk("d empty key_ready", d_kr, 1);
        w = 1;
        for (int b = 0; b < 2; b++) begin
            exp_h = '0;
            for (int c = 0; c < D_COLS; c++) begin
                g = b * D_COLS + c;
                word = kw(g / 32);
                if (word[g % 32]) exp_h = exp_h ^ rowv(c);
                @(negedge clk_in);
                d_se = 1; d_row = rowv(c); d_kv = 1; d_kd = kw(w); #1;
                chk($sformatf("d blk%0d col%0d key_ready", b, c), d_kr, (c % 32) == 31);
                chk($sformatf("d blk%0d col%0d busy", b, c), d_busy, c != 0);
                chk($sformatf("d blk%0d col%0d hash_valid", b, c), d_hv, 0);
                if ((c % 32) == 31) w++;
            end
            @(negedge clk_in);
            d_se = 0; d_kv = 0; #1;
            chk($sformatf("d blk%0d hash_valid", b), d_hv, 1);
            chk_wide($sformatf("d blk%0d hash_out", b), d_hash, exp_h);
            chk($sformatf("d blk%0d busy done", b), d_busy, 0);
            chk($sformatf("d blk%0d err", b), d_err, 0);
            @(negedge clk_in);
            d_ack = 1; #1;
            chk($sformatf("d blk%0d held", b), d_hv, 1);
            @(negedge clk_in);
            d_ack = 0; #1;
            chk($sformatf("d blk%0d acked", b), d_hv, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
